alu_sub: RTL and testbench



---
 rtl/alu_sub.sv | 133 +++++++++++++
 tb/tb_alu_sub.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_sub.sv
// alu_sub: registered subtractor slice of the lab ALU.
// Computes S = A - B with wrap, unsigned-saturate or signed-saturate result
// selection. borrow/ovf describe the raw subtraction; zero/neg describe the
// final registered S. One-cycle latency, one result per cycle, no stall.
module alu_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             out_valid,
  output logic             borrow,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam logic [1:0] MODE_WRAP  = 2'b00;
  localparam logic [1:0] MODE_USAT  = 2'b01;
  localparam logic [1:0] MODE_SSAT  = 2'b10;
  localparam logic [1:0] MODE_WRAP2 = 2'b11;

  // Largest positive two's-complement value: 0 followed by all ones.
  function automatic logic [WIDTH-1:0] signed_max();
    logic [WIDTH-1:0] v;
    v            = {WIDTH{1'b1}};
    v[WIDTH-1]   = 1'b0;
    return v;
  endfunction

  // Most negative two's-complement value: 1 followed by all zeros.
  function automatic logic [WIDTH-1:0] signed_min();
    logic [WIDTH-1:0] v;
    v            = {WIDTH{1'b0}};
    v[WIDTH-1]   = 1'b1;
    return v;
  endfunction

  // Two's-complement overflow of a - b given the raw difference msb.
  function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                        input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

  logic [WIDTH:0]   diff_s;
  logic             borrow_s;
  logic             ovf_s;
  logic [WIDTH-1:0] result_s;

  logic [WIDTH-1:0] s_r;
  logic             out_valid_r;
  logic             borrow_r;
  logic             zero_r;
  logic             neg_r;
  logic             ovf_r;

  // Raw difference A + ~B + 1 with carry-out; derive raw borrow and overflow.
  always_comb begin
    diff_s   = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    borrow_s = ~diff_s[WIDTH];
    ovf_s    = sub_overflow(A[WIDTH-1], B[WIDTH-1], diff_s[WIDTH-1]);
  end

  // Select wrapped or saturated result according to mode.
  always_comb begin
    result_s = diff_s[WIDTH-1:0];
    case (mode)
      MODE_WRAP, MODE_WRAP2: begin
        result_s = diff_s[WIDTH-1:0];
      end
      MODE_USAT: begin
        if (borrow_s) begin
          result_s = {WIDTH{1'b0}};
        end else begin
          result_s = diff_s[WIDTH-1:0];
        end
      end
      MODE_SSAT: begin
        if (ovf_s) begin
          // Clamp toward the sign of the minuend.
          if (A[WIDTH-1]) begin
            result_s = signed_min();
          end else begin
            result_s = signed_max();
          end
        end else begin
          result_s = diff_s[WIDTH-1:0];
        end
      end
      default: begin
        result_s = diff_s[WIDTH-1:0];
      end
    endcase
  end

  // Output register: load on valid, hold result and flags otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_r         <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      borrow_r    <= 1'b0;
      zero_r      <= 1'b0;
      neg_r       <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (in_valid) begin
      s_r         <= result_s;
      out_valid_r <= 1'b1;
      borrow_r    <= borrow_s;
      zero_r      <= (result_s == {WIDTH{1'b0}});
      neg_r       <= result_s[WIDTH-1];
      ovf_r       <= ovf_s;
    end else begin
      s_r         <= s_r;
      out_valid_r <= 1'b0;
      borrow_r    <= borrow_r;
      zero_r      <= zero_r;
      neg_r       <= neg_r;
      ovf_r       <= ovf_r;
    end
  end

  assign S         = s_r;
  assign out_valid = out_valid_r;
  assign borrow    = borrow_r;
  assign zero      = zero_r;
  assign neg       = neg_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_alu_sub.sv
// Scoreboard bench for alu_sub: directed vectors push hand-computed results
// into a queue; a negedge monitor pops and compares whenever out_valid is high.
module tb_alu_sub;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [7:0] s;
    logic       borrow;
    logic       zero;
    logic       neg;
    logic       ovf;
  } exp_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] mode;
    exp_t       exp;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [1:0]       mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] S;
  logic             out_valid;
  logic             borrow;
  logic             zero;
  logic             neg;
  logic             ovf;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;

  alu_sub #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode),
    .A(A), .B(B), .S(S), .out_valid(out_valid),
    .borrow(borrow), .zero(zero), .neg(neg), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp = n_cmp + 1;
    if (act !== req) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every presented result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL unexpected_out: S=0x%0h with empty scoreboard", S);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("S", {24'd0, S}, {24'd0, e.s});
        check("flags{b,z,n,o}", {28'd0, borrow, zero, neg, ovf},
              {28'd0, e.borrow, e.zero, e.neg, e.ovf});
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] m, input exp_t e);
    @(posedge clk);
    #1;
    A        = a;
    B        = b;
    mode     = m;
    in_valid = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] s_req,
                               input logic ov_req, input logic [3:0] fl_req);
    check({tag, "_S"}, {24'd0, S}, {24'd0, s_req});
    check({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, ov_req});
    check({tag, "_flags"}, {28'd0, borrow, zero, neg, ovf}, {28'd0, fl_req});
  endtask

  vec_t vecs[16];

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    mode     = 2'b00;
    A        = 8'h00;
    B        = 8'h00;

    //            A      B      mode    S     b     z     n     o
    vecs[0]  = '{8'h03, 8'h02, 2'b00, '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[1]  = '{8'h02, 8'h03, 2'b00, '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[2]  = '{8'h02, 8'h03, 2'b01, '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[3]  = '{8'h80, 8'h01, 2'b00, '{8'h7F, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[4]  = '{8'h80, 8'h01, 2'b10, '{8'h80, 1'b0, 1'b0, 1'b1, 1'b1}};
    vecs[5]  = '{8'h7F, 8'hFF, 2'b10, '{8'h7F, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[6]  = '{8'h55, 8'h55, 2'b00, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[7]  = '{8'h55, 8'h55, 2'b01, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[8]  = '{8'h55, 8'h55, 2'b10, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[9]  = '{8'h55, 8'h55, 2'b11, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[10] = '{8'hA5, 8'h00, 2'b00, '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[11] = '{8'h10, 8'h20, 2'b10, '{8'hF0, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[12] = '{8'h7F, 8'hFF, 2'b11, '{8'h80, 1'b1, 1'b0, 1'b1, 1'b1}};
    vecs[13] = '{8'h00, 8'h01, 2'b01, '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[14] = '{8'h80, 8'h7F, 2'b10, '{8'h80, 1'b0, 1'b0, 1'b1, 1'b1}};
    vecs[15] = '{8'hC8, 8'h32, 2'b01, '{8'h96, 1'b0, 1'b0, 1'b1, 1'b0}};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 8'h00, 1'b0, 4'b0000);
    rst = 1'b0;

    // Back-to-back stream of all vectors.
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].exp);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A        = 8'h01;
    B        = 8'h02;

    // Idle cycle: out_valid drops, S and flags hold the last result.
    @(posedge clk);
    #1;
    check_outputs("hold", 8'h96, 1'b0, 4'b0010);

    // Reset wins over a simultaneous valid input.
    A        = 8'h02;
    B        = 8'h03;
    mode     = 2'b00;
    in_valid = 1'b1;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("rst_vs_valid", 8'h00, 1'b0, 4'b0000);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("post_rst_idle", 8'h00, 1'b0, 4'b0000);

    // Normal operation resumes.
    issue(8'h03, 8'h02, 2'b00, '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Drain with a bounded cycle budget.
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    n_cmp = n_cmp + 1;
    if (exp_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
